// File: rtl/mnist_grid_plotter_pkg.sv
// Shared definitions for the MNIST grid plotter: FSM encoding, screen geometry
// and colour defaults.
package mnist_grid_plotter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int          SCR_W_DEF  = 160;
  localparam int          SCR_H_DEF  = 120;
  localparam logic [7:0]  THRESH_DEF = 8'd128;
  localparam logic [2:0]  FG_DEF     = 3'b111;
  localparam logic [2:0]  BG_DEF     = 3'b000;

endpackage

// File: rtl/mnist_grid_addr_gen.sv
// Coordinate walker: screen x/y plus sub-pixel and source row/col counters, so the
// source address falls out of counters instead of a divide by SCALE.
module mnist_grid_addr_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int SCALE = 2,
  parameter int X0    = 8,
  parameter int Y0    = 8,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  logic       adv,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [9:0] addr,
  output logic       last
);
  localparam int SW = $clog2(SCALE + 1);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);

  localparam logic [8:0]    X_LAST_CLR = 9'(SCR_W - 1);
  localparam logic [7:0]    Y_LAST_CLR = 8'(SCR_H - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);

  logic          clr_q;
  logic [SW-1:0] sub_x, sub_y;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          row_end;

  always_comb begin
    row_end = clr_q ? (x == X_LAST_CLR) : (col == COL_LAST && sub_x == SUB_LAST);
    last    = row_end && (clr_q ? (y == Y_LAST_CLR) : (row == ROW_LAST && sub_y == SUB_LAST));
  end

  assign addr = 10'(row) * 10'(IMG_W) + 10'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_q <= 1'b0;
      x     <= '0;
      y     <= '0;
      sub_x <= '0;
      sub_y <= '0;
      col   <= '0;
      row   <= '0;
    end else if (load) begin
      clr_q <= clear;
      x     <= clear ? 9'd0 : 9'(X0);
      y     <= clear ? 8'd0 : 8'(Y0);
      sub_x <= '0;
      sub_y <= '0;
      col   <= '0;
      row   <= '0;
    end else if (adv && !last) begin
      // final coordinate holds; the FSM leaves the issue state on it
      if (row_end) begin
        x     <= clr_q ? 9'd0 : 9'(X0);
        y     <= y + 8'd1;
        sub_x <= '0;
        col   <= '0;
        if (!clr_q) begin
          if (sub_y == SUB_LAST) begin
            sub_y <= '0;
            row   <= row + RW'(1);
          end else begin
            sub_y <= sub_y + SW'(1);
          end
        end
      end else begin
        x <= x + 9'd1;
        if (!clr_q) begin
          if (sub_x == SUB_LAST) begin
            sub_x <= '0;
            col   <= col + CW'(1);
          end else begin
            sub_x <= sub_x + SW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/mnist_grid_plotter.sv
// Drawing stage: FSM plus one-stage output register; walks the image RAM (or the
// whole screen for a clear) and emits one VGA pixel write per cycle.
module mnist_grid_plotter
  import mnist_grid_plotter_pkg::*;
#(
  parameter int         IMG_W    = 28,
  parameter int         IMG_H    = 28,
  parameter int         SCALE    = 2,
  parameter int         X0       = 8,
  parameter int         Y0       = 8,
  parameter int         SCR_W    = SCR_W_DEF,
  parameter int         SCR_H    = SCR_H_DEF,
  parameter logic [7:0] THRESH   = THRESH_DEF,
  parameter logic [2:0] FG_COLOR = FG_DEF,
  parameter logic [2:0] BG_COLOR = BG_DEF
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       clear,
  output logic [9:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOR,
  output logic       plot,
  output logic       busy,
  output logic       done
);
  localparam logic [8:0] SCR_W_L = 9'(SCR_W);
  localparam logic [7:0] SCR_H_L = 8'(SCR_H);

  state_t     state, state_nxt;
  logic       load, adv, last;
  logic [8:0] sx;
  logic [7:0] sy;
  logic       draw_q;

  mnist_grid_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .X0(X0), .Y0(Y0),
    .SCR_W(SCR_W), .SCR_H(SCR_H)
  ) u_addr_gen (
    .clk  (CLOCK_50),
    .rst_n(resetn),
    .load (load),
    .clear(clear),
    .adv  (adv),
    .x    (sx),
    .y    (sy),
    .addr (mem_addr),
    .last (last)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = clear ? S_CLEAR : S_DRAW;
        end
      end
      S_CLEAR, S_DRAW: begin
        busy = 1'b1;
        adv  = 1'b1;
        if (last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_rd = (state == S_DRAW);

  // off-screen coordinates still take their cycle but never raise plot
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      VGA_X  <= '0;
      VGA_Y  <= '0;
      plot   <= 1'b0;
      draw_q <= 1'b0;
    end else begin
      plot   <= adv && (sx < SCR_W_L) && (sy < SCR_H_L);
      draw_q <= adv && (state == S_DRAW);
      if (adv) begin
        VGA_X <= sx[7:0];
        VGA_Y <= sy[6:0];
      end
    end
  end

  assign VGA_COLOR = (draw_q && (mem_rdata >= THRESH)) ? FG_COLOR : BG_COLOR;

endmodule

// File: tb/tb_mnist_grid_plotter.sv
// Directed bench for mnist_grid_plotter: default instance for clear/draw/threshold,
// a second instance (X0=150, SCALE=1) for screen-edge clipping.
module tb_mnist_grid_plotter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start_a = 1'b0, clear_a = 1'b0, start_b = 1'b0;

  logic [9:0] addr_a, addr_b;
  logic       rd_a, rd_b, plot_a, plot_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] rdata_a, rdata_b, x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] col_a, col_b;

  logic [7:0] ram_a [0:783];
  logic [7:0] ram_b [0:783];
  logic [2:0] color_seen [0:159][0:119];

  int n_cmp = 0, n_err = 0;
  int plot_cnt, first_cyc, first_x, first_y, last_x, last_y;
  int done_cnt, done_cyc, order_err, addr_err, busy1;
  logic [9:0] addr_at3;
  logic       rd_at3;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata_a <= ram_a[addr_a];
    rdata_b <= ram_b[addr_b];
  end

  mnist_grid_plotter u_dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start_a), .clear(clear_a),
    .mem_addr(addr_a), .mem_rd(rd_a), .mem_rdata(rdata_a),
    .VGA_X(x_a), .VGA_Y(y_a), .VGA_COLOR(col_a), .plot(plot_a),
    .busy(busy_a), .done(done_a)
  );

  mnist_grid_plotter #(.X0(150), .SCALE(1)) u_clip (
    .CLOCK_50(clk), .resetn(resetn), .start(start_b), .clear(1'b0),
    .mem_addr(addr_b), .mem_rd(rd_b), .mem_rdata(rdata_b),
    .VGA_X(x_b), .VGA_Y(y_b), .VGA_COLOR(col_b), .plot(plot_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic fill_checker();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        ram_a[r*28+c] = ((r + c) % 2 == 0) ? 8'd255 : 8'd0;
  endtask

  // Runs one job on the default instance, recording what it plots cycle by cycle.
  task automatic run_a(input bit clr, input int mid_pulse, input int ncyc);
    int k, ex, ey;
    bit prev_rd;
    logic [9:0] prev_addr;
    for (int xx = 0; xx < 160; xx++)
      for (int yy = 0; yy < 120; yy++) color_seen[xx][yy] = 3'bxxx;
    plot_cnt = 0; first_cyc = -1; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    done_cnt = 0; done_cyc = -1; order_err = 0; addr_err = 0; busy1 = 0;
    addr_at3 = 'x; rd_at3 = 1'b0; prev_rd = 1'b0; prev_addr = '0;
    @(negedge clk); start_a = 1'b1; clear_a = clr;
    @(negedge clk); start_a = 1'b0; clear_a = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == mid_pulse) begin start_a = 1'b1; clear_a = 1'b1; end
      else if (cyc == mid_pulse + 1) begin start_a = 1'b0; clear_a = 1'b0; end
      if (cyc == 1) busy1 = busy_a;
      if (cyc == 3) begin addr_at3 = addr_a; rd_at3 = rd_a; end
      if (plot_a) begin
        k  = plot_cnt;
        ex = clr ? k % 160 : 8 + k % 56;
        ey = clr ? k / 160 : 8 + k / 56;
        if (int'(x_a) != ex || int'(y_a) != ey) order_err++;
        if (!clr && (!prev_rd || int'(prev_addr) != ((int'(y_a) - 8) / 2) * 28 + (int'(x_a) - 8) / 2))
          addr_err++;
        if (first_cyc < 0) begin first_cyc = cyc; first_x = x_a; first_y = y_a; end
        if (x_a < 160 && y_a < 120) color_seen[x_a][y_a] = col_a;
        last_x = x_a; last_y = y_a;
        plot_cnt++;
      end
      if (done_a) begin done_cnt++; done_cyc = cyc; end
      prev_rd = rd_a; prev_addr = addr_a;
    end
    start_a = 1'b0; clear_a = 1'b0;
  endtask

  task automatic test_reset();
    int pc;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (plot_a !== 1'b0) begin n_err++; $display("FAIL rst_plot: got %b want 0", plot_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_a); end
    n_cmp++; if (x_a !== 8'd0 || y_a !== 7'd0) begin n_err++; $display("FAIL rst_xy: got (%0d,%0d) want (0,0)", x_a, y_a); end
    n_cmp++; if (col_a !== 3'b000) begin n_err++; $display("FAIL rst_color: got %b want 000", col_a); end
    n_cmp++; if (rd_a !== 1'b0 || addr_a !== 10'd0) begin n_err++; $display("FAIL rst_mem: got rd=%b addr=%0d want 0/0", rd_a, addr_a); end
    resetn = 1'b1;
    @(negedge clk);
    fill_checker();
    start_a = 1'b1; clear_a = 1'b0;
    @(negedge clk); start_a = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b1 || plot_a !== 1'b1) begin n_err++; $display("FAIL abort_pre: got busy=%b plot=%b want 1/1", busy_a, plot_a); end
    resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (plot_a !== 1'b0 || busy_a !== 1'b0) begin n_err++; $display("FAIL abort_ctl: got plot=%b busy=%b want 0/0", plot_a, busy_a); end
    n_cmp++; if (x_a !== 8'd0 || y_a !== 7'd0) begin n_err++; $display("FAIL abort_xy: got (%0d,%0d) want (0,0)", x_a, y_a); end
    @(negedge clk); resetn = 1'b1;
    pc = 0;
    repeat (6) begin @(negedge clk); if (plot_a || busy_a) pc++; end
    n_cmp++; if (pc != 0) begin n_err++; $display("FAIL abort_after: got %0d active cycles want 0", pc); end
  endtask

  task automatic test_clear();
    int bad = 0;
    run_a(1'b1, -5, 19205);
    for (int xx = 0; xx < 160; xx++)
      for (int yy = 0; yy < 120; yy++) if (color_seen[xx][yy] !== 3'b000) bad++;
    n_cmp++; if (busy1 != 1) begin n_err++; $display("FAIL clr_busy1: got %0d want 1", busy1); end
    n_cmp++; if (first_cyc != 2 || first_x != 0 || first_y != 0) begin n_err++; $display("FAIL clr_first: got cyc%0d (%0d,%0d) want cyc2 (0,0)", first_cyc, first_x, first_y); end
    n_cmp++; if (last_x != 159 || last_y != 119) begin n_err++; $display("FAIL clr_last: got (%0d,%0d) want (159,119)", last_x, last_y); end
    n_cmp++; if (plot_cnt != 19200) begin n_err++; $display("FAIL clr_count: got %0d want 19200", plot_cnt); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 19202) begin n_err++; $display("FAIL clr_done: got %0d pulses at %0d want 1 at 19202", done_cnt, done_cyc); end
    n_cmp++; if (order_err != 0) begin n_err++; $display("FAIL clr_order: got %0d errors want 0", order_err); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clr_color: got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_draw();
    int bad = 0;
    logic [2:0] ec;
    fill_checker();
    run_a(1'b0, -5, 3141);
    for (int yy = 8; yy < 64; yy++)
      for (int xx = 8; xx < 64; xx++) begin
        ec = (ram_a[((yy - 8) / 2) * 28 + (xx - 8) / 2] >= 8'd128) ? 3'b111 : 3'b000;
        if (color_seen[xx][yy] !== ec) bad++;
      end
    n_cmp++; if (first_cyc != 2 || first_x != 8 || first_y != 8) begin n_err++; $display("FAIL drw_first: got cyc%0d (%0d,%0d) want cyc2 (8,8)", first_cyc, first_x, first_y); end
    n_cmp++; if (color_seen[8][8] !== 3'b111 || color_seen[9][9] !== 3'b111) begin n_err++; $display("FAIL drw_fg: got %b/%b want 111/111", color_seen[8][8], color_seen[9][9]); end
    n_cmp++; if (color_seen[10][8] !== 3'b000) begin n_err++; $display("FAIL drw_bg: got %b want 000", color_seen[10][8]); end
    n_cmp++; if (addr_at3 !== 10'd1 || rd_at3 !== 1'b1) begin n_err++; $display("FAIL drw_addr_sx10: got addr=%0d rd=%b want 1/1", addr_at3, rd_at3); end
    n_cmp++; if (addr_err != 0) begin n_err++; $display("FAIL drw_addr: got %0d errors want 0", addr_err); end
    n_cmp++; if (order_err != 0) begin n_err++; $display("FAIL drw_order: got %0d errors want 0", order_err); end
    n_cmp++; if (plot_cnt != 3136) begin n_err++; $display("FAIL drw_count: got %0d want 3136", plot_cnt); end
    n_cmp++; if (last_x != 63 || last_y != 63) begin n_err++; $display("FAIL drw_last: got (%0d,%0d) want (63,63)", last_x, last_y); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 3138) begin n_err++; $display("FAIL drw_done: got %0d pulses at %0d want 1 at 3138", done_cnt, done_cyc); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL drw_color: got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_threshold();
    int nfg;
    for (int i = 0; i < 784; i++) ram_a[i] = 8'd0;
    ram_a[0] = 8'd127;
    run_a(1'b0, -5, 3141);
    nfg = 0;
    for (int xx = 8; xx < 10; xx++) for (int yy = 8; yy < 10; yy++) if (color_seen[xx][yy] !== 3'b000) nfg++;
    n_cmp++; if (nfg != 0) begin n_err++; $display("FAIL thr_127: got %0d non-bg pixels want 0", nfg); end
    ram_a[0] = 8'd128;
    ram_a[1] = 8'd255;
    run_a(1'b0, -5, 3141);
    nfg = 0;
    for (int xx = 8; xx < 10; xx++) for (int yy = 8; yy < 10; yy++) if (color_seen[xx][yy] === 3'b111) nfg++;
    n_cmp++; if (nfg != 4) begin n_err++; $display("FAIL thr_128: got %0d fg pixels want 4", nfg); end
    n_cmp++; if (color_seen[10][8] !== 3'b111 || color_seen[12][8] !== 3'b000) begin n_err++; $display("FAIL thr_neighbours: got %b/%b want 111/000", color_seen[10][8], color_seen[12][8]); end
  endtask

  task automatic test_clip();
    int busy_cnt = 0, pc = 0, bad = 0, dcyc = -1, fx = -1, lx = -1, ly = -1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int cyc = 1; cyc <= 792; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (busy_b) busy_cnt++;
      if (plot_b) begin
        if (fx < 0) fx = x_b;
        if (x_b < 150 || x_b > 159 || y_b < 8 || y_b > 35 || col_b !== 3'b111) bad++;
        lx = x_b; ly = y_b; pc++;
      end
      if (done_b) dcyc = cyc;
    end
    n_cmp++; if (busy_cnt != 785) begin n_err++; $display("FAIL clip_busy: got %0d cycles want 785", busy_cnt); end
    n_cmp++; if (pc != 280) begin n_err++; $display("FAIL clip_count: got %0d want 280", pc); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clip_range: got %0d bad plots want 0", bad); end
    n_cmp++; if (dcyc != 786) begin n_err++; $display("FAIL clip_done: got %0d want 786", dcyc); end
    n_cmp++; if (fx != 150 || lx != 159 || ly != 35) begin n_err++; $display("FAIL clip_ends: got first x %0d last (%0d,%0d) want 150 (159,35)", fx, lx, ly); end
  endtask

  task automatic test_start_busy();
    int bad = 0;
    logic [2:0] ec;
    fill_checker();
    run_a(1'b0, 500, 3141);
    for (int yy = 8; yy < 64; yy++)
      for (int xx = 8; xx < 64; xx++) begin
        ec = (ram_a[((yy - 8) / 2) * 28 + (xx - 8) / 2] >= 8'd128) ? 3'b111 : 3'b000;
        if (color_seen[xx][yy] !== ec) bad++;
      end
    n_cmp++; if (plot_cnt != 3136 || order_err != 0) begin n_err++; $display("FAIL busy_start_count: got %0d plots %0d order errors want 3136/0", plot_cnt, order_err); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 3138) begin n_err++; $display("FAIL busy_start_done: got %0d pulses at %0d want 1 at 3138", done_cnt, done_cyc); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL busy_start_color: got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    fill_checker();
    @(negedge clk); start_a = 1'b1; clear_a = 1'b0;
    @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL b2b_done1: got no done within 4000 cycles want done"); end
    start_a = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL b2b_done_ignored: got busy=%b want 0", busy_a); end
    @(negedge clk); start_a = 1'b0;
    n_cmp++; if (busy_a !== 1'b1 || plot_a !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got busy=%b plot=%b want 1/0", busy_a, plot_a); end
    @(negedge clk);
    n_cmp++; if (plot_a !== 1'b1 || x_a !== 8'd8 || y_a !== 7'd8) begin n_err++; $display("FAIL b2b_first: got plot=%b (%0d,%0d) want 1 (8,8)", plot_a, x_a, y_a); end
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL b2b_done2: got no done within 4000 cycles want done"); end
  endtask

  initial begin
    for (int i = 0; i < 784; i++) begin ram_a[i] = 8'd0; ram_b[i] = 8'd255; end
    test_reset();
    test_clear();
    test_draw();
    test_threshold();
    test_clip();
    test_start_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
